// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encodings and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_RUN   = 2'd1,
        ST_KILL  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int unsigned START_DLY_DEF = 2;
    localparam int unsigned CNT_W_DEF     = 16;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: decodes hazards into per-stage enables/flushes,
// drains after reset, discards wrong-path fetches, halts, and counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned START_DLY = START_DLY_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DRAIN_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
    localparam int unsigned DRAIN_LAST_I = (START_DLY > 0) ? START_DLY - 1 : 0;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LAST_I);
    localparam state_e RESET_ST = (START_DLY == 0) ? ST_RUN : ST_DRAIN;

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [4:0]         en;    // {pc, ifid, idex, exmem, memwb}
    logic [1:0]         flush; // {ifid, idex}
    logic               inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_ST;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        en      = 5'b00000;
        flush   = 2'b00;
        inc     = 1'b0;
        unique case (state_q)
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_RUN, ST_KILL: begin
                if (halt_wb) begin
                    state_d = ST_HALT;
                end else if (dmem_stall) begin
                    inc = 1'b1;
                end else if (br_taken) begin
                    en    = 5'b11111;
                    flush = 2'b11;
                    if (imem_stall || (state_q == ST_KILL)) begin
                        state_d = ST_KILL;
                    end
                end else if (state_q == ST_KILL) begin
                    // Outstanding wrong-path fetch: hold PC on the target, bubble IF/ID.
                    en    = 5'b01111;
                    flush = 2'b10;
                    if (imem_stall) begin
                        inc = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (load_use) begin
                    en    = 5'b00111;
                    flush = 2'b01;
                    inc   = 1'b1;
                end else if (imem_stall) begin
                    en    = 5'b01111;
                    flush = 2'b10;
                    inc   = 1'b1;
                end else begin
                    en = 5'b11111;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = RESET_ST;
            end
        endcase
        if (!rst) begin
            en    = 5'b00000;
            flush = 2'b00;
        end
    end

    assign pc_en      = en[4];
    assign ifid_en    = en[3];
    assign idex_en    = en[2];
    assign exmem_en   = en[1];
    assign memwb_en   = en[0];
    assign ifid_flush = flush[1];
    assign idex_flush = flush[0];
    assign halted     = (state_q == ST_HALT);

    sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (inc),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a START_DLY=1, CNT_W=4
// instance sharing the same stimulus.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic load_use, br_taken, imem_stall, dmem_stall, halt_wb;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
    logic [15:0] stall_cnt;
    logic pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4, halted4;
    logic [3:0] stall_cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .START_DLY (2),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .imem_stall (imem_stall),
        .dmem_stall (dmem_stall),
        .halt_wb    (halt_wb),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    pipe_ctrl #(
        .START_DLY (1),
        .CNT_W     (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .imem_stall (imem_stall),
        .dmem_stall (dmem_stall),
        .halt_wb    (halt_wb),
        .pc_en      (pc_en4),
        .ifid_en    (ifid_en4),
        .idex_en    (idex_en4),
        .exmem_en   (exmem_en4),
        .memwb_en   (memwb_en4),
        .ifid_flush (ifid_flush4),
        .idex_flush (idex_flush4),
        .halted     (halted4),
        .stall_cnt  (stall_cnt4)
    );

    wire [4:0] en_v  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [1:0] fl_v  = {ifid_flush, idex_flush};
    wire [4:0] en4_v = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] en_exp, input logic [1:0] fl_exp,
                             input int stall_exp, input logic halt_exp);
        check_eq({tag, "_en"}, 32'(en_v), 32'(en_exp));
        check_eq({tag, "_flush"}, 32'(fl_v), 32'(fl_exp));
        check_eq({tag, "_stall"}, 32'(stall_cnt), 32'(stall_exp));
        check_eq({tag, "_halted"}, 32'(halted), 32'(halt_exp));
    endtask

    task automatic set_in(input logic lu, input logic br, input logic ims, input logic dms,
                          input logic hw);
        load_use   = lu;
        br_taken   = br;
        imem_stall = ims;
        dmem_stall = dms;
        halt_wb    = hw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        check_out("reset", 5'b00000, 2'b00, 0, 1'b0);
        set_in(1, 1, 1, 1, 1);
        check_out("reset_inputs_hi", 5'b00000, 2'b00, 0, 1'b0);
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();

        // Release: two drain cycles on dut, one on dut4.
        rst = 1'b1;
        #1;
        check_out("drain0", 5'b00000, 2'b00, 0, 1'b0);
        check_eq("drain0_en4", 32'(en4_v), 32'h00);
        tick();
        check_out("drain1", 5'b00000, 2'b00, 0, 1'b0);
        check_eq("drain1_en4", 32'(en4_v), 32'h1f);
        tick();
        check_out("run0", 5'b11111, 2'b00, 0, 1'b0);

        set_in(1, 0, 0, 0, 0);
        check_out("load_use", 5'b00111, 2'b01, 0, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check_out("after_lu", 5'b11111, 2'b00, 1, 1'b0);

        // Taken branch while fetch outstanding -> KILL for two stalled cycles.
        set_in(0, 1, 1, 0, 0);
        check_out("br_ims", 5'b11111, 2'b11, 1, 1'b0);
        tick();
        set_in(0, 0, 1, 0, 0);
        check_out("kill1", 5'b01111, 2'b10, 1, 1'b0);
        tick();
        check_out("kill2", 5'b01111, 2'b10, 2, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check_out("kill_ret", 5'b01111, 2'b10, 3, 1'b0);
        tick();
        check_out("kill_run", 5'b11111, 2'b00, 3, 1'b0);

        // dmem_stall with br_taken: freeze wins until dmem_stall drops.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 1, 0);
            check_out($sformatf("freeze%0d", i), 5'b00000, 2'b00, 3 + i, 1'b0);
            tick();
        end
        set_in(0, 1, 0, 0, 0);
        check_out("freeze_flush", 5'b11111, 2'b11, 7, 1'b0);
        tick();
        set_in(1, 1, 0, 0, 0);
        check_out("lu_br", 5'b11111, 2'b11, 7, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check_out("lu_br_nocnt", 5'b11111, 2'b00, 7, 1'b0);

        // imem_stall for 20 cycles: dut4 (4-bit) saturates at 15.
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 1, 0, 0);
            if (i == 0 || i == 19) begin
                check_out($sformatf("ims%0d", i), 5'b01111, 2'b10, 7 + i, 1'b0);
            end
            if (i == 10) begin
                check_eq("sat_mid", 32'(stall_cnt4), 32'd15);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        check_eq("sat_end", 32'(stall_cnt4), 32'd15);
        check_out("ims_done", 5'b11111, 2'b00, 27, 1'b0);

        // Halt: sticky, ignores hazards.
        set_in(0, 0, 0, 0, 1);
        check_out("halt_req", 5'b00000, 2'b00, 27, 1'b0);
        tick();
        set_in(1, 1, 1, 0, 0);
        check_out("halted_a", 5'b00000, 2'b00, 27, 1'b1);
        tick();
        set_in(0, 0, 1, 1, 1);
        check_out("halted_b", 5'b00000, 2'b00, 27, 1'b1);
        tick();
        set_in(1, 0, 0, 0, 0);
        check_out("halted_c", 5'b00000, 2'b00, 27, 1'b1);

        // Mid-halt reset clears everything immediately; then drain again.
        rst = 1'b0;
        #1;
        check_out("rst_mid", 5'b00000, 2'b00, 0, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_out("redrain0", 5'b00000, 2'b00, 0, 1'b0);
        check_eq("redrain0_en4", 32'(en4_v), 32'h00);
        tick();
        check_out("redrain1", 5'b00000, 2'b00, 0, 1'b0);
        check_eq("redrain1_en4", 32'(en4_v), 32'h1f);
        tick();
        check_out("rerun", 5'b11111, 2'b00, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
